// File: rtl/mem_access_unit_pkg.sv
// Shared constants, state encoding and small helpers for the data-RAM access unit.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The RAM treats this select value as a no-op.
    localparam logic [3:0] SEL_IDLE = 4'b1110;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3)
            F3_H, F3_HU: return 3'd2;
            F3_W:        return 3'd4;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input logic [2:0] funct3);
        case (access_size(funct3))
            3'd1:    return 32'h0000_00ff;
            3'd2:    return 32'h0000_ffff;
            default: return 32'hffff_ffff;
        endcase
    endfunction

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of a load/store request: opcode, alignment and RAM bounds.
module mem_req_check #(
    parameter int MEM_BYTES   = 4096,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    output logic        err
);
    import mem_pkg::*;

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] last_byte;

    always_comb begin
        illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111)
               || (we && ((funct3 == F3_BU) || (funct3 == F3_HU)));
        misaligned = (ALIGN_CHECK != 0)
                  && ((((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0])
                   || ((funct3 == F3_W) && (addr[1:0] != 2'b00)));
        // 33-bit sum so an access near 2^32 cannot wrap back into range
        last_byte    = {1'b0, addr} + 33'(access_size(funct3)) - 33'd1;
        out_of_range = last_byte >= 33'(MEM_BYTES);
        err          = illegal || misaligned || out_of_range;
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data RAM: check, hold the bus, return a response.
module mem_access_unit #(
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_CYCLES = 1,
    parameter int ALIGN_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    import mem_pkg::*;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    op_funct3;
    logic          op_we;
    logic          chk_err;

    mem_req_check #(
        .MEM_BYTES   (MEM_BYTES),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_check (
        .we     (req_we),
        .funct3 (req_funct3),
        .addr   (req_addr),
        .err    (chk_err)
    );

    // Gated by rst so the unit never looks ready while held in reset.
    assign req_ready = (state == IDLE) && !rst;

    // Extension is redone here; upper RAM bits for narrow loads are not trusted.
    function automatic logic [31:0] extend(input logic [2:0] funct3, input logic [31:0] r);
        case (funct3)
            F3_B:    return {{24{r[7]}}, r[7:0]};
            F3_H:    return {{16{r[15]}}, r[15:0]};
            F3_BU:   return {24'd0, r[7:0]};
            F3_HU:   return {16'd0, r[15:0]};
            default: return r;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_funct3 <= 3'd0;
            op_we     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_sel   <= SEL_IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_funct3 <= req_funct3;
                        op_we     <= req_we;
                        if (chk_err) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            state     <= ACCESS;
                            wait_cnt  <= CW'(WAIT_CYCLES - 1);
                            mem_addr  <= req_addr;
                            mem_sel   <= {req_funct3, req_we};
                            mem_wdata <= req_wdata & width_mask(req_funct3);
                        end
                    end
                end
                ACCESS: begin
                    if (wait_cnt == '0) begin
                        state     <= RESP;
                        mem_sel   <= SEL_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= op_we ? 32'd0 : extend(op_funct3, mem_rdata);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
